fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the instruction-fetch datapath. It owns the architectural PC, issues single-word reads to a multi-cycle instruction memory, and buffers the returned word. The word is presented to decode through a valid/ready handshake. It handles branch/jump redirects, including squashing a read already in flight, HALT, and misaligned-PC errors. It sits between the memory port and the fetch/decode pipeline register.

## Interface
Parameters:
- RESET_PC, 16'h0000: PC loaded on reset. Must be even.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- mem_rd, out, 1: read request strobe, held for exactly one accepted cycle.
- mem_addr, out, 16: read address. Equals the PC whenever mem_rd=1.
- mem_stall, in, 1: memory cannot accept a request this cycle.
- mem_done, in, 1: read data valid this cycle.
- mem_data, in, 16: read data, sampled when mem_done=1.
- redir_valid, in, 1: redirect request from execute.
- redir_pc, in, 16: redirect target.
- halt_req, in, 1: decode has accepted a HALT instruction.
- out_valid, out, 1: instr, pc_out and pc_plus2 are valid.
- out_ready, in, 1: decode accepts the output this cycle.
- instr, out, 16: fetched instruction.
- pc_out, out, 16: address of instr.
- pc_plus2, out, 16: pc_out + 2, modulo 2^16.
- halted, out, 1: controller is in HALT.
- err, out, 1: sticky misaligned-fetch error.

## Operation
The FSM has four states:
- REQ
  - Drive mem_rd=1 and mem_addr=PC.
  - If mem_stall=1: stay in REQ and re-present the request next cycle.
  - Otherwise: go to WAIT.
- WAIT
  - mem_rd=0.
  - On mem_done: capture mem_data into the instr register and go to HOLD.
  - If the squash flag is set: drop the data, clear squash, go to REQ.
- HOLD
  - out_valid=1.
  - On out_valid & out_ready: PC <= PC+2, go to REQ.
- HALT
  - mem_rd=0, out_valid=0, halted=1.
  - Exited only by rst.

Redirect rules (redir_valid=1 has priority over every other event in the same cycle):
- In REQ: PC <= redir_pc and stay in REQ. The stale request is not issued if mem_stall=1; if it was accepted this cycle, set squash and go to WAIT.
- In WAIT: PC <= redir_pc and set squash.
- In HOLD: drop the held word, PC <= redir_pc, go to REQ, out_valid=0 next cycle.
- In HALT: ignored.
- Alignment check: if redir_pc[0]=1, set err (sticky) and go to HALT instead.

HALT request:
- halt_req=1 with no redirect in the same cycle: go to HALT from any state.
- An outstanding read still completes on the memory side; its mem_done is ignored.

Other rules:
- mem_done outside WAIT is ignored.
- pc_plus2 comes from the adder with carry-out discarded, so 16'hFFFE + 2 = 16'h0000.

Reset values:
- State = REQ, PC = RESET_PC, squash = 0, err = 0, instr = 16'h0000.
- Outputs: mem_rd=1 (combinational from REQ), mem_addr=RESET_PC, out_valid=0, halted=0.

## Timing
- mem_rd and mem_addr are combinational from state and PC. All other outputs are registered.
- Request accepted at cycle t with mem_done at t+k (k≥1): out_valid=1 from t+k+1.
- Accept at cycle a: next mem_rd at a+1.
- Best-case throughput: one instruction per 3 cycles when k=1 and out_ready is held at 1.
- out_valid, instr and pc_out remain stable while out_ready=0.
- Redirect at cycle r: first request to redir_pc is at r+1, or later if squashing an in-flight read.
- Asynchronous rst mid-read: the FSM returns to REQ immediately, and any later mem_done is ignored because state ≠ WAIT.

## Structure
- fetch_pkg holds:
  - State enum: REQ, WAIT, HOLD, HALT, 2-bit.
  - Width constant PC_W=16.
  - Increment constant PC_INC=16'h2.
- The PC+2 increment instantiates the existing cla16b, with cIn=0 and cOut unconnected.
- The FSM, PC, instr and squash registers stay inline in one module.

## Test plan
- Reset with RESET_PC=16'h0000, memory k=1, out_ready=1:
  - Expect mem_addr 0000, 0002, 0004 on mem_rd cycles three cycles apart.
  - Expect pc_out to match and pc_plus2 = pc_out+2.
- out_ready=0 for 5 cycles in HOLD with instr=16'h1234:
  - out_valid stays 1 and instr stays 1234.
  - No mem_rd pulses.
  - On release, the next mem_addr = pc_out+2.
- redir_valid with redir_pc=16'h0100 in WAIT (k=3):
  - The returning word is dropped and out_valid stays 0.
  - The next mem_rd has mem_addr=0100.
  - The first out_valid shows pc_out=0100.
- mem_stall=1 for 4 cycles in REQ: mem_rd stays 1 with a stable mem_addr, and exactly one read is issued afterward.
- redir_valid with redir_pc=16'h0101:
  - err=1 and halted=1 next cycle, with no further mem_rd.
  - halt_req in HOLD also gives halted=1 and out_valid=0.
  - rst clears both.
- PC=16'hFFFE accepted: pc_plus2 = 16'h0000 and the next mem_addr = 16'h0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'h2;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  // Instructions are 16-bit words, so any odd fetch address is illegal.
  function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
    return pc[0];
  endfunction

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups tied together by
// a second lookahead level.
module cla16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cIn,
  output logic [15:0] sum,
  output logic        cOut
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    localparam int B = 4 * k;
    assign grp_g[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1]) |
                      (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p[k] = &p[B +: 4];
    assign c[B]     = grp_c[k];
    assign c[B+1]   = g[B] | (p[B] & grp_c[k]);
    assign c[B+2]   = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[k]);
    assign c[B+3]   = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B]) |
                      (p[B+2] & p[B+1] & p[B] & grp_c[k]);
  end

  // Group carries are expanded directly from cIn so no carry ripples between groups.
  assign grp_c[0] = cIn;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cIn);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cIn);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0]) |
                    (grp_p[2] & grp_p[1] & grp_p[0] & cIn);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1]) |
                    (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]) |
                    (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cIn);

  assign sum  = p ^ c;
  assign cOut = grp_c[4];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues single-word memory reads,
// buffers the returned word for decode and handles redirects, HALT and errors.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_rd,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_stall,
  input  logic            mem_done,
  input  logic [PC_W-1:0] mem_data,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            halt_req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus2,
  output logic            halted,
  output logic            err
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_plus2_q, pc_plus2_d;
  logic [PC_W-1:0] instr_q, instr_d;
  logic            squash_q, squash_d;
  logic            err_q, err_d;
  logic            unused_cout;

  // The adder works on the next PC so that PC+2 is registered alongside the PC itself.
  cla16b u_pc_inc (
    .a    (pc_d),
    .b    (PC_INC),
    .cIn  (1'b0),
    .sum  (pc_plus2_d),
    .cOut (unused_cout)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    squash_d = squash_q;
    err_d    = err_q;

    if (state_q != HALT && redir_valid && is_misaligned(redir_pc)) begin
      err_d    = 1'b1;
      squash_d = 1'b0;
      state_d  = HALT;
    end else begin
      case (state_q)
        REQ: begin
          if (redir_valid) begin
            pc_d = redir_pc;
            // A stale request the memory accepted this cycle must be thrown away.
            if (!mem_stall) begin
              squash_d = 1'b1;
              state_d  = WAIT;
            end
          end else if (halt_req) begin
            state_d = HALT;
          end else if (!mem_stall) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (redir_valid) begin
            pc_d = redir_pc;
            // If the stale word arrives in the redirect cycle, there is nothing left to squash.
            if (mem_done) begin
              squash_d = 1'b0;
              state_d  = REQ;
            end else begin
              squash_d = 1'b1;
            end
          end else if (halt_req) begin
            squash_d = 1'b0;
            state_d  = HALT;
          end else if (mem_done) begin
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = REQ;
            end else begin
              instr_d = mem_data;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (redir_valid) begin
            pc_d    = redir_pc;
            state_d = REQ;
          end else if (halt_req) begin
            state_d = HALT;
          end else if (out_ready) begin
            pc_d    = pc_plus2_q;
            state_d = REQ;
          end
        end
        HALT: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      pc_plus2_q <= RESET_PC + PC_INC;
      instr_q    <= '0;
      squash_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus2_q <= pc_plus2_d;
      instr_q    <= instr_d;
      squash_q   <= squash_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd    = (state_q == REQ);
  assign mem_addr  = pc_q;
  assign out_valid = (state_q == HOLD);
  assign halted    = (state_q == HALT);
  assign instr     = instr_q;
  assign pc_out    = pc_q;
  assign pc_plus2  = pc_plus2_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl, with a latency-configurable
// memory and a transaction-level model of the expected fetch stream.
module tb_fetch_ctrl;

  localparam logic [15:0] RESET_PC_TB = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_data;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic        mem_busy;
  int          mem_cnt;
  int          mem_k;
  logic [15:0] mem_pend_addr;
  logic        data_ovr_en;
  logic [15:0] data_ovr;
  int          accepts;
  logic [15:0] acc_addr[$];
  int          acc_cyc[$];

  logic        model_on;
  logic [15:0] exp_pc;
  int          handshakes;
  logic        hold_prev;
  logic [15:0] prev_instr;
  logic [15:0] prev_pc;

  fetch_ctrl #(.RESET_PC(RESET_PC_TB)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_stall   (mem_stall),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halt_req    (halt_req),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus2    (pc_plus2),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory contents are a fixed scramble of the address.
  function automatic logic [15:0] memFn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, observe the request, advance the model.
  task automatic applyStimulus();
    logic        acc;
    logic [15:0] acc_a;
    mem_done = 1'b0;
    mem_data = 16'($urandom);
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busy = 1'b0;
        mem_done = 1'b1;
        mem_data = data_ovr_en ? data_ovr : memFn(mem_pend_addr);
      end
    end
    #1;
    acc   = mem_rd && !mem_stall;
    acc_a = mem_addr;
    if (acc) begin
      accepts++;
      acc_addr.push_back(acc_a);
      acc_cyc.push_back(cyc);
    end
    if (model_on) begin
      if (acc) checkOutput("rd_addr", acc_a, exp_pc);
      if (hold_prev) begin
        checkOutput("hold_valid", 16'(out_valid), 16'h1);
        checkOutput("hold_instr", instr, prev_instr);
        checkOutput("hold_pc", pc_out, prev_pc);
      end
      if (out_valid && out_ready && !redir_valid) begin
        checkOutput("hs_pc", pc_out, exp_pc);
        checkOutput("hs_instr", instr, memFn(exp_pc));
        checkOutput("hs_pc_plus2", pc_plus2, exp_pc + 16'h2);
        exp_pc = exp_pc + 16'h2;
        handshakes++;
      end
      hold_prev  = out_valid && !out_ready && !redir_valid;
      prev_instr = instr;
      prev_pc    = pc_out;
      if (redir_valid) exp_pc = redir_pc;
    end
    @(posedge clk);
    cyc++;
    if (acc) begin
      mem_busy      = 1'b1;
      mem_cnt       = (mem_k == 0) ? int'($urandom_range(1, 3)) : mem_k;
      mem_pend_addr = acc_a;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst         = 1'b1;
    mem_stall   = 1'b0;
    mem_done    = 1'b0;
    mem_data    = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    halt_req    = 1'b0;
    out_ready   = 1'b0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_k       = 1;
    data_ovr_en = 1'b0;
    data_ovr    = '0;
    accepts     = 0;
    acc_addr.delete();
    acc_cyc.delete();
    model_on    = 1'b0;
    exp_pc      = RESET_PC_TB;
    handshakes  = 0;
    hold_prev   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Reset values, then back-to-back fetches with single-cycle memory.
    doReset();
    checkOutput("rst_mem_rd", 16'(mem_rd), 16'h1);
    checkOutput("rst_mem_addr", mem_addr, RESET_PC_TB);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);
    checkOutput("rst_halted", 16'(halted), 16'h0);
    checkOutput("rst_err", 16'(err), 16'h0);
    checkOutput("rst_instr", instr, 16'h0000);
    mem_k     = 1;
    out_ready = 1'b1;
    model_on  = 1'b1;
    repeat (9) applyStimulus();
    checkOutput("t1_nreads", 16'(acc_addr.size()), 16'd3);
    checkOutput("t1_handshakes", 16'(handshakes), 16'd3);
    for (int i = 0; i < 3 && i < acc_addr.size(); i++) begin
      checkOutput("t1_addr", acc_addr[i], 16'(2 * i));
      checkOutput("t1_spacing", 16'(acc_cyc[i] - acc_cyc[0]), 16'(3 * i));
    end

    // Back-pressure in HOLD keeps the word stable and blocks new reads.
    doReset();
    mem_k       = 1;
    data_ovr_en = 1'b1;
    data_ovr    = 16'h1234;
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus();
    checkOutput("t2_valid_reached", 16'(out_valid), 16'h1);
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_valid", 16'(out_valid), 16'h1);
      checkOutput("t2_instr", instr, 16'h1234);
      checkOutput("t2_pc", pc_out, 16'h0000);
      checkOutput("t2_no_rd", 16'(mem_rd), 16'h0);
      applyStimulus();
    end
    checkOutput("t2_no_accepts", 16'(accepts), 16'h0);
    out_ready = 1'b1;
    applyStimulus();
    out_ready = 1'b0;
    checkOutput("t2_next_rd", 16'(mem_rd), 16'h1);
    checkOutput("t2_next_addr", mem_addr, 16'h0002);

    // Redirect while a slow read is in flight: returning word must be dropped.
    doReset();
    mem_k     = 3;
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("t3_in_wait", 16'(mem_rd), 16'h0);
    redir_valid = 1'b1;
    redir_pc    = 16'h0100;
    applyStimulus();
    redir_valid = 1'b0;
    acc_addr.delete();
    for (int i = 0; i < 12 && acc_addr.size() == 0; i++) begin
      checkOutput("t3_no_valid", 16'(out_valid), 16'h0);
      applyStimulus();
    end
    checkOutput("t3_read_issued", 16'(acc_addr.size()), 16'd1);
    if (acc_addr.size() > 0) checkOutput("t3_addr", acc_addr[0], 16'h0100);
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus();
    checkOutput("t3_valid", 16'(out_valid), 16'h1);
    checkOutput("t3_pc_out", pc_out, 16'h0100);
    checkOutput("t3_instr", instr, memFn(16'h0100));

    // Memory stall holds the request until it is accepted exactly once.
    doReset();
    mem_k     = 3;
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_rd_held", 16'(mem_rd), 16'h1);
      checkOutput("t4_addr_held", mem_addr, 16'h0000);
      applyStimulus();
    end
    checkOutput("t4_none_accepted", 16'(accepts), 16'h0);
    mem_stall = 1'b0;
    repeat (6) applyStimulus();
    checkOutput("t4_one_read", 16'(accepts), 16'h1);

    // Misaligned redirect halts with a sticky error.
    doReset();
    redir_valid = 1'b1;
    redir_pc    = 16'h0101;
    applyStimulus();
    redir_valid = 1'b0;
    checkOutput("t5_err", 16'(err), 16'h1);
    checkOutput("t5_halted", 16'(halted), 16'h1);
    checkOutput("t5_no_rd", 16'(mem_rd), 16'h0);
    checkOutput("t5_no_valid", 16'(out_valid), 16'h0);
    accepts   = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      redir_valid = 1'b1;
      redir_pc    = 16'($urandom) & 16'hFFFE;
      applyStimulus();
    end
    redir_valid = 1'b0;
    checkOutput("t5_stays_quiet", 16'(accepts), 16'h0);
    checkOutput("t5_stays_halted", 16'(halted), 16'h1);
    doReset();
    checkOutput("t5_rst_err", 16'(err), 16'h0);
    checkOutput("t5_rst_halted", 16'(halted), 16'h0);
    mem_k = 1;
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus();
    checkOutput("t5_hold_reached", 16'(out_valid), 16'h1);
    halt_req = 1'b1;
    applyStimulus();
    halt_req = 1'b0;
    checkOutput("t5_halt_halted", 16'(halted), 16'h1);
    checkOutput("t5_halt_valid", 16'(out_valid), 16'h0);
    checkOutput("t5_halt_err", 16'(err), 16'h0);
    doReset();
    checkOutput("t5_rst2_halted", 16'(halted), 16'h0);

    // PC wrap at the top of the address space.
    doReset();
    mem_stall   = 1'b1;
    redir_valid = 1'b1;
    redir_pc    = 16'hFFFE;
    applyStimulus();
    redir_valid = 1'b0;
    mem_stall   = 1'b0;
    checkOutput("t6_rd", 16'(mem_rd), 16'h1);
    checkOutput("t6_addr", mem_addr, 16'hFFFE);
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus();
    checkOutput("t6_valid", 16'(out_valid), 16'h1);
    checkOutput("t6_pc_out", pc_out, 16'hFFFE);
    checkOutput("t6_pc_plus2", pc_plus2, 16'h0000);
    checkOutput("t6_instr", instr, memFn(16'hFFFE));
    out_ready = 1'b1;
    applyStimulus();
    out_ready = 1'b0;
    checkOutput("t6_wrap_rd", 16'(mem_rd), 16'h1);
    checkOutput("t6_wrap_addr", mem_addr, 16'h0000);

    // Asynchronous reset during a read; the late response must be ignored.
    doReset();
    mem_k = 1;
    applyStimulus();
    #2 rst = 1'b1;
    #1;
    checkOutput("t7_async_rd", 16'(mem_rd), 16'h1);
    checkOutput("t7_async_addr", mem_addr, RESET_PC_TB);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();
    checkOutput("t7_late_done_ignored", 16'(out_valid), 16'h0);
    for (int i = 0; i < 10 && !out_valid; i++) applyStimulus();
    checkOutput("t7_valid", 16'(out_valid), 16'h1);
    checkOutput("t7_pc_out", pc_out, RESET_PC_TB);
    checkOutput("t7_instr", instr, memFn(RESET_PC_TB));

    // Randomized traffic against the fetch-stream model.
    doReset();
    mem_k    = 0;
    model_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      mem_stall   = ($urandom_range(0, 3) == 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      redir_valid = ($urandom_range(0, 19) == 0);
      redir_pc    = ($urandom_range(0, 7) == 0) ? (16'hFFFC | 16'(2 * $urandom_range(0, 1)))
                                                : (16'($urandom) & 16'hFFFE);
      applyStimulus();
    end
    redir_valid = 1'b0;
    checkOutput("rnd_progress", 16'(handshakes > 100), 16'h1);
    checkOutput("rnd_no_err", 16'(err), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
